// File: rtl/demux_stream.sv
// demux_stream: routes a valid/ready input stream to one of NCH output channels.
// It can also broadcast a beat to every channel.
// Each channel has a one-entry output register that can drain and reload on the same edge.
// A unicast beat addressed beyond the last channel is accepted and dropped.
// The drop raises a one-cycle err pulse and bumps a saturating counter.
module demux_stream #(
    parameter int WIDTH = 8,
    parameter int NCH   = 4,
    parameter int SELW  = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_data,
    input  logic [SELW-1:0]      in_sel,
    input  logic                 bcast,
    output logic [NCH-1:0]       out_valid,
    input  logic [NCH-1:0]       out_ready,
    output logic [NCH*WIDTH-1:0] out_data,
    output logic                 err,
    output logic [7:0]           drop_cnt
);

    // Every encoding of in_sel gets an entry in free_ext.
    // Selecting the channel's free flag is then a plain index.
    localparam int NSEL = 1 << SELW;
    localparam logic [SELW:0] NCH_L = (SELW + 1)'(NCH);

    logic [NCH-1:0]  slot_free;
    logic [NSEL-1:0] free_ext;
    logic            in_range;
    logic            accept;
    logic            drop;
    logic            err_q;
    logic [7:0]      drop_cnt_q;
    logic [7:0]      drop_cnt_d;

    genvar gi;

    // Encodings past the last channel always read as free.
    // An out-of-range beat is therefore always accepted, and then discarded.
    for (gi = 0; gi < NSEL; gi++) begin : g_free
        if (gi < NCH) begin : g_real
            assign free_ext[gi] = slot_free[gi];
        end else begin : g_oob
            assign free_ext[gi] = 1'b1;
        end
    end

    // in_ready never looks at in_valid.
    // A broadcast needs every slot free, so there is never a partial delivery.
    assign in_ready = bcast ? (&slot_free) : free_ext[in_sel];
    assign in_range = ({1'b0, in_sel} < NCH_L);
    assign accept   = in_valid & in_ready;
    assign drop     = accept & ~bcast & ~in_range;

    // Per-channel output slot.
    // A load takes priority over a drain, so a slot that drains and loads on one edge keeps valid high.
    for (gi = 0; gi < NCH; gi++) begin : g_ch
        logic             valid_q;
        logic             valid_d;
        logic             load;
        logic [WIDTH-1:0] data_q;
        logic [WIDTH-1:0] data_d;

        assign slot_free[gi] = ~valid_q | out_ready[gi];
        assign load          = accept & (bcast | (in_sel == SELW'(gi)));
        assign valid_d       = load | (valid_q & ~out_ready[gi]);
        assign data_d        = load ? in_data : data_q;

        // Slot register; the data is kept after a drain until the next load.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                valid_q <= 1'b0;
                data_q  <= '0;
            end else begin
                valid_q <= valid_d;
                data_q  <= data_d;
            end
        end

        assign out_valid[gi]               = valid_q;
        assign out_data[gi*WIDTH +: WIDTH] = data_q;
    end

    // The drop counter stops at its ceiling instead of wrapping.
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (drop && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end
    end

    // err pulses for exactly the cycle after a drop; the counter is registered alongside it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q      <= 1'b0;
            drop_cnt_q <= 8'd0;
        end else begin
            err_q      <= drop;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign err      = err_q;
    assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_demux_stream.sv
// Testbench for demux_stream with three channels, so that in_sel=3 is out of range.
// Stimulus pushes expected beats into per-channel queues.
// A separate monitor pops a queue whenever a channel hands a beat downstream.
module tb_demux_stream;

    localparam int WIDTH = 8;
    localparam int NCH   = 3;
    localparam int SELW  = 2;

    logic                 clk;
    logic                 rst_n;
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     in_data;
    logic [SELW-1:0]      in_sel;
    logic                 bcast;
    logic [NCH-1:0]       out_valid;
    logic [NCH-1:0]       out_ready;
    logic [NCH*WIDTH-1:0] out_data;
    logic                 err;
    logic [7:0]           drop_cnt;

    demux_stream #(.WIDTH(WIDTH), .NCH(NCH), .SELW(SELW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .bcast     (bcast),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .err       (err),
        .drop_cnt  (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: the beats each channel still owes downstream, in delivery order.
    logic [WIDTH-1:0] exp_q [NCH][$];
    logic [WIDTH-1:0] last_pop [NCH];
    bit               err_exp_q [$];
    int               drop_exp;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: one line per delivered beat, plus checks of err, drop_cnt and every slot.
    always begin
        @(negedge clk);
        #1;
        if (!rst_n) begin
            check("rst_out_valid", 32'(out_valid), 32'd0);
            check("rst_out_data", 32'(out_data), 32'd0);
            check("rst_err", 32'(err), 32'd0);
            check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
            for (int i = 0; i < NCH; i++) begin
                exp_q[i].delete();
                last_pop[i] = '0;
            end
            err_exp_q.delete();
            drop_exp = 0;
        end else begin
            bit e;
            e = (err_exp_q.size() > 0) ? err_exp_q.pop_front() : 1'b0;
            check("err", 32'(err), 32'(e));
            if (e && drop_exp < 255) drop_exp++;
            check("drop_cnt", 32'(drop_cnt), 32'(drop_exp));
            for (int i = 0; i < NCH; i++) begin
                bit occ;
                occ = (exp_q[i].size() > 0);
                check($sformatf("out_valid[%0d]", i), 32'(out_valid[i]), 32'(occ));
                if (occ) begin
                    check($sformatf("out_data[%0d]", i), 32'(out_data[i*WIDTH +: WIDTH]), 32'(exp_q[i][0]));
                    if (out_ready[i]) begin
                        last_pop[i] = exp_q[i].pop_front();
                        $display("deliver ch%0d data=%02h t=%0t", i, last_pop[i], $time);
                    end
                end else begin
                    check($sformatf("idle_data[%0d]", i), 32'(out_data[i*WIDTH +: WIDTH]), 32'(last_pop[i]));
                end
            end
        end
    end

    // Drive one cycle of input and check in_ready against the model.
    // When the beat is accepted, push what is expected to come out.
    task automatic drive(input bit v, input logic [SELW-1:0] s, input bit b,
                         input logic [WIDTH-1:0] d, input logic [NCH-1:0] r);
        bit exp_rdy;
        @(negedge clk);
        in_valid  = v;
        in_sel    = s;
        bcast     = b;
        in_data   = d;
        out_ready = r;
        #2;
        if (rst_n) begin
            // A slot can take a beat when it owes nothing, or when it is handing its beat over now.
            if (b) begin
                exp_rdy = 1'b1;
                for (int i = 0; i < NCH; i++)
                    if (exp_q[i].size() > 0 && !r[i]) exp_rdy = 1'b0;
            end else if (int'(s) < NCH) begin
                exp_rdy = (exp_q[s].size() == 0) || r[s];
            end else begin
                exp_rdy = 1'b1;
            end
            check("in_ready", 32'(in_ready), 32'(exp_rdy));
            if (v && in_ready) begin
                if (b) begin
                    for (int i = 0; i < NCH; i++) exp_q[i].push_back(d);
                end else if (int'(s) < NCH) begin
                    exp_q[s].push_back(d);
                end
                err_exp_q.push_back(!b && int'(s) >= NCH);
            end else begin
                err_exp_q.push_back(1'b0);
            end
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(1'b0, '0, 1'b0, '0, '1);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_sel    = '0;
        bcast     = 1'b0;
        in_data   = '0;
        out_ready = '0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;

        // Unicast 0xA5 to channel 2 with every channel ready.
        drive(1'b1, 2'd2, 1'b0, 8'hA5, '1);
        #5 check("a5_valid", 32'(out_valid), 32'b100);
        check("a5_data", 32'(out_data[2*WIDTH +: WIDTH]), 32'hA5);
        idle(2);

        // Channel 1 stalled: 0x11 is held, and 0x22 waits until channel 1 drains.
        drive(1'b1, 2'd1, 1'b0, 8'h11, 3'b101);
        drive(1'b1, 2'd1, 1'b0, 8'h22, 3'b101);
        drive(1'b1, 2'd1, 1'b0, 8'h22, 3'b101);
        drive(1'b1, 2'd1, 1'b0, 8'h22, 3'b111);
        #5 check("ch1_follow", 32'(out_data[1*WIDTH +: WIDTH]), 32'h22);
        idle(2);

        // Channel 2 stalled blocks a broadcast until it is released.
        drive(1'b1, 2'd2, 1'b0, 8'h99, 3'b011);
        drive(1'b1, 2'd0, 1'b1, 8'h3C, 3'b011);
        drive(1'b1, 2'd0, 1'b1, 8'h3C, 3'b011);
        drive(1'b1, 2'd0, 1'b1, 8'h3C, 3'b111);
        #5 check("bcast_valid", 32'(out_valid), 32'b111);
        check("bcast_data", 32'(out_data), {8'h0, 24'h3C3C3C});
        idle(2);

        // Channel 0 drains and loads on the same edge.
        drive(1'b1, 2'd0, 1'b0, 8'h66, 3'b110);
        drive(1'b1, 2'd0, 1'b0, 8'h77, 3'b111);
        #5 check("reload_valid0", 32'(out_valid[0]), 32'd1);
        check("reload_data0", 32'(out_data[WIDTH-1:0]), 32'h77);
        idle(2);

        // Randomised traffic; in_sel=3 is out of range.
        for (int k = 0; k < 1500; k++) begin
            drive(1'($urandom_range(0, 3) != 0), SELW'($urandom_range(0, 3)),
                  1'($urandom_range(0, 5) == 0), WIDTH'($urandom),
                  NCH'($urandom | $urandom));
        end
        idle(3);

        // 300 out-of-range beats: err pulses on each one, and drop_cnt stops at 255.
        for (int k = 0; k < 300; k++) drive(1'b1, 2'd3, 1'b0, WIDTH'($urandom), '1);
        idle(1);
        check("drop_sat", 32'(drop_cnt), 32'd255);

        // Asynchronous reset while channel 0 holds 0x55.
        drive(1'b1, 2'd0, 1'b0, 8'h55, 3'b000);
        #5 check("hold55_valid", 32'(out_valid), 32'b001);
        check("hold55_data", 32'(out_data[WIDTH-1:0]), 32'h55);
        rst_n = 1'b0;
        #1 check("async_valid", 32'(out_valid), 32'd0);
        check("async_data", 32'(out_data), 32'd0);
        check("async_drop", 32'(drop_cnt), 32'd0);
        check("async_err", 32'(err), 32'd0);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;

        // A beat can be accepted on the first edge after reset is released.
        drive(1'b1, 2'd1, 1'b0, 8'hC3, '1);
        #5 check("first_accept", 32'(out_valid), 32'b010);
        for (int k = 0; k < 200; k++) begin
            drive(1'($urandom_range(0, 1)), SELW'($urandom_range(0, 3)),
                  1'($urandom_range(0, 7) == 0), WIDTH'($urandom), NCH'($urandom));
        end
        idle(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/demux_stream.md
DEMUX_STREAM -- requirements
Module: demux_stream

Interface
REQ-001 SHALL provide parameter WIDTH, default 8, data width of each beat in bits.
REQ-002 SHALL provide parameter NCH, default 4, number of output channels (legal range 2..16).
REQ-003 SHALL provide parameter SELW, default 2, select width, equal to ceil(log2(NCH)).
REQ-004 clk  input  1  single clock, all state updates on its rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset, deassertion synchronous to clk externally.
REQ-006 in_valid  input  1  input beat present.
REQ-007 in_ready  output  1  block can accept the presented beat this cycle.
REQ-008 in_data  input  WIDTH  input beat payload.
REQ-009 in_sel  input  SELW  destination channel for a unicast beat.
REQ-010 bcast  input  1  beat goes to every channel (in_sel ignored).
REQ-011 out_valid  output  NCH  per-channel beat present, bit i for channel i.
REQ-012 out_ready  input  NCH  per-channel downstream accept.
REQ-013 out_data  output  NCH*WIDTH  channel i payload at bits [i*WIDTH +: WIDTH].
REQ-014 err  output  1  one-cycle pulse on a dropped out-of-range beat.
REQ-015 drop_cnt  output  8  count of dropped beats, saturating.

Function
REQ-016 Each channel SHALL hold a one-entry output register (valid flag plus WIDTH data).
REQ-017 A channel slot SHALL count as free in a cycle when its valid is 0 or its out_ready is 1.
REQ-018 Unicast (bcast=0, in_sel<NCH): in_ready SHALL equal the free condition of channel in_sel.
REQ-019 Broadcast (bcast=1): in_ready SHALL be 1 only when all NCH slots are free; no partial delivery.
REQ-020 Out-of-range (bcast=0, in_sel>=NCH): in_ready SHALL be 1; the accepted beat is discarded.
REQ-021 A beat SHALL be accepted on a rising edge where in_valid and in_ready are both 1.
REQ-022 Latency: an accepted beat SHALL appear on out_valid/out_data of its channel(s) on the next cycle.
REQ-023 A channel SHALL hold out_valid and out_data stable until the cycle out_ready is 1.
REQ-024 A slot with out_valid=1 and out_ready=1 and no new load SHALL clear out_valid next cycle.
REQ-025 Simultaneous drain and load of one slot SHALL leave out_valid=1 with the new data; no bubble, no loss.
REQ-026 Back-to-back beats to a continuously ready channel SHALL sustain one beat per cycle.
REQ-027 Beats to different channels SHALL be independent; a stalled channel SHALL NOT block unicast to another.
REQ-028 out_data of a channel with out_valid=0 SHALL keep its last loaded value (0 after reset).
REQ-029 in_ready SHALL be combinational from in_sel, bcast, out_valid, out_ready; no path from in_valid.
REQ-030 On an out-of-range acceptance err SHALL be 1 for exactly the next cycle; otherwise 0.
REQ-031 drop_cnt SHALL increment by 1 per out-of-range acceptance and hold at 255.
REQ-032 Channel order on out_data SHALL be channel 0 in the least significant WIDTH bits.

Reset
REQ-033 While rst_n=0 all out_valid SHALL be 0, all out_data 0, err 0, drop_cnt 0, asynchronously.
REQ-034 Reset mid-transfer SHALL discard every held beat; no beat accepted in the reset cycle.
REQ-035 First acceptance SHALL be possible on the first rising edge with rst_n=1.

Verification
REQ-036 Reset, then unicast 0xA5 to ch2, out_ready=all 1 -> next cycle out_valid=0100, ch2 data 0xA5, then 0000.
REQ-037 Ch1 out_ready=0, send 0x11 then 0x22 to ch1 -> 0x11 held, in_ready=0 for second beat until ch1 ready; 0x22 follows 0x11 with no gap.
REQ-038 Ch3 stalled, bcast 0x3C -> in_ready=0; release ch3 -> all four channels show 0x3C same cycle.
REQ-039 NCH=3, in_sel=3 with in_valid=1 for 300 cycles -> err pulses per beat, no out_valid, drop_cnt stops at 255.
REQ-040 Ch0 full and draining while 0x77 loaded same edge -> out_valid[0] stays 1, data 0x77, no beat lost.
REQ-041 rst_n low while ch0 holds 0x55 -> out_valid, out_data, drop_cnt go 0 immediately, without waiting for clk.
